// File: rtl/lock_session_ctrl.sv
// Entry-session sequencer for one lock core: arm, digit forwarding, verdict wait, open/fail/lockout.
// Defining LOCK_SESSION_BACKOFF_EN doubles each successive lockout (x1, x2, x4, capped at x8).
module lock_session_ctrl #(
    parameter int CODE_LEN       = 4,
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 16,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int RESULT_TIMEOUT = 8,
    parameter int ENTRY_TIMEOUT  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       lock_out,
    input  logic       lock_buzzer,
    output logic       lock_start_n,
    output logic       lock_rst_n,
    output logic [3:0] lock_digit,
    output logic       lock_dv,
    output logic       unlocked,
    output logic       alarm,
    output logic       busy,
    output logic [2:0] fail_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_ENTRY   = 3'd2,
        S_WAIT    = 3'd3,
        S_OPEN    = 3'd4,
        S_FAIL    = 3'd5,
        S_LOCKOUT = 3'd6,
        S_CLEAR   = 3'd7
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

`ifdef LOCK_SESSION_BACKOFF_EN
    localparam int LOCK_MAX = LOCKOUT_CYCLES * 8;
`else
    localparam int LOCK_MAX = LOCKOUT_CYCLES;
`endif
    // One timer serves every timed state; it is sized for the longest of them.
    localparam int T_MAX = max2(max2(OPEN_CYCLES, LOCK_MAX), max2(RESULT_TIMEOUT, ENTRY_TIMEOUT));
    localparam int TMR_W = $clog2(T_MAX + 1);
    localparam int DC_W  = $clog2(CODE_LEN + 1);

    localparam logic [TMR_W-1:0] OPEN_LAST   = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] RESULT_LAST = TMR_W'(RESULT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] ENTRY_LAST  = TMR_W'(ENTRY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST0  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [DC_W-1:0]  DIG_LAST    = DC_W'(CODE_LEN - 1);
    localparam logic [2:0]       MAX_F       = 3'(MAX_FAILS);

    state_t            state_r;
    state_t            state_next_s;
    logic              tmr_run_s;
    logic [TMR_W-1:0]  tmr_r;
    logic [TMR_W-1:0]  lock_last_s;
    logic [DC_W-1:0]   dcnt_r;
    logic [2:0]        fail_cnt_r;
    logic              lock_start_n_r;
    logic              lock_rst_n_r;
    logic [3:0]        lock_digit_r;
    logic              lock_dv_r;
    logic              unlocked_r;
    logic              alarm_r;
    logic              busy_r;

`ifdef LOCK_SESSION_BACKOFF_EN
    logic [1:0] backoff_r;
    logic [1:0] lo_shift_r;

    // Backoff level: the current lockout uses the level captured on entry, then the level rises
    always_ff @(posedge clk) begin
        if (reset) begin
            backoff_r  <= 2'd0;
            lo_shift_r <= 2'd0;
        end else if (state_r == S_FAIL && state_next_s == S_LOCKOUT) begin
            lo_shift_r <= backoff_r;
            backoff_r  <= (backoff_r == 2'd3) ? backoff_r : backoff_r + 2'd1;
        end else if (state_r == S_WAIT && state_next_s == S_OPEN) begin
            backoff_r  <= 2'd0;
            lo_shift_r <= lo_shift_r;
        end else begin
            backoff_r  <= backoff_r;
            lo_shift_r <= lo_shift_r;
        end
    end

    // Terminal timer value for the lockout in progress
    always_comb begin
        lock_last_s = LOCK_LAST0;
        case (lo_shift_r)
            2'd0:    lock_last_s = LOCK_LAST0;
            2'd1:    lock_last_s = TMR_W'(LOCKOUT_CYCLES * 2 - 1);
            2'd2:    lock_last_s = TMR_W'(LOCKOUT_CYCLES * 4 - 1);
            2'd3:    lock_last_s = TMR_W'(LOCKOUT_CYCLES * 8 - 1);
            default: lock_last_s = LOCK_LAST0;
        endcase
    end
`else
    assign lock_last_s = LOCK_LAST0;
`endif

    // Next-state decode and timer enable
    always_comb begin
        state_next_s = state_r;
        tmr_run_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req) state_next_s = S_ARM;
                else     state_next_s = S_IDLE;
            end
            S_ARM: state_next_s = S_ENTRY;
            S_ENTRY: begin
                tmr_run_s = 1'b1;
                // A key on the timeout cycle wins over the abort.
                if (key_valid) begin
                    if (dcnt_r == DIG_LAST) state_next_s = S_WAIT;
                    else                    state_next_s = S_ENTRY;
                end else if (tmr_r == ENTRY_LAST) begin
                    state_next_s = S_CLEAR;
                end else begin
                    state_next_s = S_ENTRY;
                end
            end
            S_WAIT: begin
                tmr_run_s = 1'b1;
                if (lock_buzzer)                state_next_s = S_FAIL;
                else if (lock_out)              state_next_s = S_OPEN;
                else if (tmr_r == RESULT_LAST)  state_next_s = S_FAIL;
                else                            state_next_s = S_WAIT;
            end
            S_OPEN: begin
                tmr_run_s = 1'b1;
                if (tmr_r == OPEN_LAST) state_next_s = S_CLEAR;
                else                    state_next_s = S_OPEN;
            end
            S_FAIL: begin
                if (fail_cnt_r == MAX_F) state_next_s = S_LOCKOUT;
                else                     state_next_s = S_CLEAR;
            end
            S_LOCKOUT: begin
                tmr_run_s = 1'b1;
                if (tmr_r == lock_last_s) state_next_s = S_CLEAR;
                else                      state_next_s = S_LOCKOUT;
            end
            S_CLEAR: state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, shared timer and digit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            tmr_r   <= {TMR_W{1'b0}};
            dcnt_r  <= {DC_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (!tmr_run_s || state_next_s != state_r || (state_r == S_ENTRY && key_valid))
                tmr_r <= {TMR_W{1'b0}};
            else
                tmr_r <= tmr_r + TMR_W'(1);
            if (state_r == S_ARM)
                dcnt_r <= {DC_W{1'b0}};
            else if (state_r == S_ENTRY && key_valid)
                dcnt_r <= dcnt_r + DC_W'(1);
            else
                dcnt_r <= dcnt_r;
        end
    end

    // Consecutive-failure counter: bumped on FAIL entry, cleared by an open or an expired lockout
    always_ff @(posedge clk) begin
        if (reset)
            fail_cnt_r <= 3'd0;
        else if (state_next_s == S_FAIL && state_r != S_FAIL)
            fail_cnt_r <= (fail_cnt_r == 3'd7) ? fail_cnt_r : fail_cnt_r + 3'd1;
        else if (state_r == S_WAIT && state_next_s == S_OPEN)
            fail_cnt_r <= 3'd0;
        else if (state_r == S_LOCKOUT && state_next_s == S_CLEAR)
            fail_cnt_r <= 3'd0;
        else
            fail_cnt_r <= fail_cnt_r;
    end

    // Registered outputs, decoded from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_start_n_r <= 1'b1;
            lock_rst_n_r   <= 1'b0;
            lock_digit_r   <= 4'd0;
            lock_dv_r      <= 1'b0;
            unlocked_r     <= 1'b0;
            alarm_r        <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            lock_start_n_r <= (state_next_s != S_ARM);
            lock_rst_n_r   <= (state_next_s != S_CLEAR);
            unlocked_r     <= (state_next_s == S_OPEN);
            alarm_r        <= (state_next_s == S_LOCKOUT);
            busy_r         <= (state_next_s != S_IDLE);
            lock_dv_r      <= (state_r == S_ENTRY) && key_valid;
            if (state_r == S_ENTRY && key_valid)
                lock_digit_r <= key_digit;
            else
                lock_digit_r <= lock_digit_r;
        end
    end

    assign lock_start_n = lock_start_n_r;
    assign lock_rst_n   = lock_rst_n_r;
    assign lock_digit   = lock_digit_r;
    assign lock_dv      = lock_dv_r;
    assign unlocked     = unlocked_r;
    assign alarm        = alarm_r;
    assign busy         = busy_r;
    assign fail_cnt     = fail_cnt_r;
    assign state        = state_r;

endmodule

// File: doc/lock_session_ctrl.md
Name: lock_session_ctrl

Overview:
- Session controller sequencing one `lock` datapath instance.
- Starts an entry session on user request and forwards keypad digits to the lock with a valid strobe.
- Waits for the lock's accept/reject verdict, then holds the door open or counts the failure.
- Enforces an alarmed lockout after repeated failures. Sits between keypad/button front end and the lock core.

Parameters:
- CODE_LEN, 4, digits per code entry (1..15).
- MAX_FAILS, 3, consecutive failures that trigger lockout (1..7).
- OPEN_CYCLES, 16, cycles `unlocked` is held after acceptance.
- LOCKOUT_CYCLES, 64, base lockout duration in cycles.
- RESULT_TIMEOUT, 8, max cycles to wait for lock verdict.
- ENTRY_TIMEOUT, 32, max idle cycles between digits before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req  in  1  level; request a new entry session.
- key_valid  in  1  one-cycle strobe, key_digit valid.
- key_digit  in  4  keypad digit.
- lock_out  in  1  lock verdict: code accepted.
- lock_buzzer  in  1  lock verdict: code rejected.
- lock_start_n  out  1  active-low start pulse to lock.
- lock_rst_n  out  1  active-low clear to lock.
- lock_digit  out  4  registered digit to lock.
- lock_dv  out  1  one-cycle strobe with lock_digit.
- unlocked  out  1  door-open indication.
- alarm  out  1  lockout active.
- busy  out  1  high in every state except IDLE.
- fail_cnt  out  3  consecutive failure count.
- state  out  3  FSM state code, for debug.

Behaviour:
- State codes: IDLE=0, ARM=1, ENTRY=2, WAIT=3, OPEN=4, FAIL=5, LOCKOUT=6, CLEAR=7.
- All outputs are registered.

Reset:
- On the next edge with reset=1: state=IDLE, lock_start_n=1, lock_rst_n=0, lock_digit=0, lock_dv=0, unlocked=0, alarm=0, busy=0, fail_cnt=0.
- All timers and counters clear. Reset mid-session aborts with no fail increment.
- lock_rst_n returns to 1 on the first edge after reset deasserts.

State transitions:
- IDLE: req=1 -> ARM. key_valid is ignored.
- ARM: lock_start_n=0 for exactly this one cycle. Digit counter cleared -> ENTRY.
- ENTRY:
  - On key_valid: lock_digit<=key_digit and lock_dv=1 on the next cycle; digit counter +1; idle timer cleared.
  - After the CODE_LEN-th digit's strobe -> WAIT.
  - If the idle timer reaches ENTRY_TIMEOUT with no key_valid: abort -> CLEAR. Not counted as a fail.
- WAIT:
  - lock_buzzer=1 -> FAIL. If lock_out and lock_buzzer are both high in the same cycle, FAIL wins.
  - lock_out=1 -> OPEN.
  - RESULT_TIMEOUT cycles without a verdict -> FAIL.
  - key_valid is ignored.
- OPEN: unlocked=1 for exactly OPEN_CYCLES cycles; fail_cnt<=0 on entry -> CLEAR.
- FAIL: one cycle; fail_cnt saturating +1. If new value == MAX_FAILS -> LOCKOUT, else -> CLEAR.
- LOCKOUT:
  - alarm=1 for the lockout duration; req is ignored.
  - At expiry: fail_cnt<=0, alarm<=0 -> CLEAR.
- CLEAR: lock_rst_n=0 for one cycle -> IDLE.

Other rules:
- req held high re-arms a new session immediately after returning to IDLE; one IDLE cycle is mandatory between sessions.
- Timer widths are $clog2(param+1). Counters never wrap; the FSM leaves the state on reaching the terminal count.
- A key_valid arriving in the same cycle as the ENTRY timeout is accepted; the timeout does not fire.

Optional Feature:
- Macro: LOCK_SESSION_BACKOFF_EN.
- Defined: each successive lockout doubles its duration: LOCKOUT_CYCLES, x2, x4, capped at x8.
  - A 2-bit backoff level increments at each LOCKOUT entry, saturating at 3.
  - The backoff level clears only on an OPEN entry or on reset.
- Undefined: every lockout is exactly LOCKOUT_CYCLES; no backoff register exists.

Test Plan:
- Good code: req=1, keys 1,0,1,1 one per 2 cycles, lock_out=1 two cycles after the last digit.
  - Expect: lock_start_n low for 1 cycle; 4 lock_dv pulses carrying 1,0,1,1.
  - Expect: unlocked high exactly 16 cycles, then a 1-cycle lock_rst_n=0, then IDLE, fail_cnt=0.
- Three rejections: three sessions, each answered by lock_buzzer=1.
  - Expect: fail_cnt 1, 2, then 3, then LOCKOUT; alarm high exactly 64 cycles.
  - Expect: req ignored during lockout; afterwards fail_cnt=0.
- Verdict timeout: 4 digits entered, no lock_out or lock_buzzer -> FAIL after 8 cycles in WAIT; fail_cnt=1.
- Entry timeout: 2 digits, then silence -> abort at 32 idle cycles; lock_rst_n pulse; fail_cnt unchanged.
- Simultaneous/reset cases:
  - lock_out and lock_buzzer high in the same cycle -> FAIL.
  - reset=1 during OPEN -> next cycle unlocked=0, state=IDLE, lock_rst_n=0.
- With LOCK_SESSION_BACKOFF_EN defined: two back-to-back lockouts -> alarm durations 64 then 128 cycles; a subsequent good code restores 64.
